// File: rtl/alu_rsv_station_pkg.sv
// alu_rsv_station_pkg: shared widths, entry layout and CDB snoop helper for the ALU reservation station
package alu_rsv_station_pkg;
  localparam int RS_SIZE = 16;
  localparam int RS_IDX_W = 4;
  localparam int OP_ID_W = 6;
  localparam int ROB_ID_W = 4;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic busy;
    logic [OP_ID_W-1:0] op;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] vj;
    logic qj_busy;
    logic [ROB_ID_W-1:0] qj;
    logic [DATA_W-1:0] vk;
    logic qk_busy;
    logic [ROB_ID_W-1:0] qk;
    logic [DATA_W-1:0] imm;
    logic [ROB_ID_W-1:0] rob_id;
  } rs_entry_t;
  function automatic logic [DATA_W:0] snoop(
    input logic q_busy, input logic [ROB_ID_W-1:0] q,
    input logic a_v, input logic [ROB_ID_W-1:0] a_id, input logic [DATA_W-1:0] a_val,
    input logic l_v, input logic [ROB_ID_W-1:0] l_id, input logic [DATA_W-1:0] l_val);
    return (q_busy && a_v && a_id == q) ? {1'b1, a_val} :
           (q_busy && l_v && l_id == q) ? {1'b1, l_val} : '0;
  endfunction
endpackage

// File: rtl/rs_priority_enc.sv
// rs_priority_enc: lowest-set-bit index of a request vector plus a found flag
module rs_priority_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);
  // scan downward so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    found = |req;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = i[W-1:0];
  end
endmodule

// File: rtl/alu_rsv_station.sv
// alu_rsv_station: holds ALU-class instructions until operands arrive and issues one per cycle
module alu_rsv_station
  import alu_rsv_station_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                DP_input_valid,
  input  logic [OP_ID_W-1:0]  DP_OP_ID,
  input  logic [DATA_W-1:0]   DP_inst_pc,
  input  logic [DATA_W-1:0]   DP_Vj,
  input  logic                DP_Qj_busy,
  input  logic [ROB_ID_W-1:0] DP_Qj,
  input  logic [DATA_W-1:0]   DP_Vk,
  input  logic                DP_Qk_busy,
  input  logic [ROB_ID_W-1:0] DP_Qk,
  input  logic [DATA_W-1:0]   DP_imm,
  input  logic [ROB_ID_W-1:0] DP_ROB_id,
  output logic                RS_full,
  input  logic                ALU_cdb_valid,
  input  logic [ROB_ID_W-1:0] ALU_cdb_ROB_id,
  input  logic [DATA_W-1:0]   ALU_cdb_value,
  input  logic                LSB_cdb_valid,
  input  logic [ROB_ID_W-1:0] LSB_cdb_ROB_id,
  input  logic [DATA_W-1:0]   LSB_cdb_value,
  input  logic                ROB_clear,
  output logic                ALU_input_valid,
  output logic [OP_ID_W-1:0]  ALU_OP_ID,
  output logic [DATA_W-1:0]   ALU_inst_pc,
  output logic [DATA_W-1:0]   ALU_reg_rs1,
  output logic [DATA_W-1:0]   ALU_reg_rs2,
  output logic [DATA_W-1:0]   ALU_imm,
  output logic [ROB_ID_W-1:0] ALU_ROB_id
);
  rs_entry_t ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy_v, ready_v;
  logic [DATA_W:0] sj [RS_SIZE];
  logic [DATA_W:0] sk [RS_SIZE];
  logic [DATA_W:0] dj, dk;
  logic [RS_IDX_W-1:0] free_idx, rdy_idx;
  logic free_found, rdy_found;
  // per-entry status vectors and CDB snoop results, ALU bus taking precedence
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_v[i] = ent[i].busy;
      ready_v[i] = ent[i].busy && !ent[i].qj_busy && !ent[i].qk_busy;
      sj[i] = snoop(ent[i].qj_busy, ent[i].qj, ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
                    LSB_cdb_valid, LSB_cdb_ROB_id, LSB_cdb_value);
      sk[i] = snoop(ent[i].qk_busy, ent[i].qk, ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
                    LSB_cdb_valid, LSB_cdb_ROB_id, LSB_cdb_value);
    end
    dj = snoop(DP_Qj_busy, DP_Qj, ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
               LSB_cdb_valid, LSB_cdb_ROB_id, LSB_cdb_value);
    dk = snoop(DP_Qk_busy, DP_Qk, ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
               LSB_cdb_valid, LSB_cdb_ROB_id, LSB_cdb_value);
  end
  assign RS_full = &busy_v;
  rs_priority_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (.req(~busy_v), .idx(free_idx), .found(free_found));
  rs_priority_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_rdy_enc (.req(ready_v), .idx(rdy_idx), .found(rdy_found));
  // entry array and issue register: flush, then wakeup, issue and dispatch in one edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      ALU_input_valid <= 1'b0;
      ALU_OP_ID <= '0;
      ALU_inst_pc <= '0;
      ALU_reg_rs1 <= '0;
      ALU_reg_rs2 <= '0;
      ALU_imm <= '0;
      ALU_ROB_id <= '0;
    end else if (rdy) begin
      if (ROB_clear) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
        ALU_input_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent[i].busy && sj[i][DATA_W]) begin
            ent[i].vj <= sj[i][DATA_W-1:0];
            ent[i].qj_busy <= 1'b0;
          end
          if (ent[i].busy && sk[i][DATA_W]) begin
            ent[i].vk <= sk[i][DATA_W-1:0];
            ent[i].qk_busy <= 1'b0;
          end
        end
        ALU_input_valid <= rdy_found;
        if (rdy_found) begin
          ALU_OP_ID <= ent[rdy_idx].op;
          ALU_inst_pc <= ent[rdy_idx].pc;
          ALU_reg_rs1 <= ent[rdy_idx].vj;
          ALU_reg_rs2 <= ent[rdy_idx].vk;
          ALU_imm <= ent[rdy_idx].imm;
          ALU_ROB_id <= ent[rdy_idx].rob_id;
          ent[rdy_idx].busy <= 1'b0;
        end
        if (DP_input_valid && free_found)
          ent[free_idx] <= '{busy: 1'b1, op: DP_OP_ID, pc: DP_inst_pc,
                             vj: dj[DATA_W] ? dj[DATA_W-1:0] : DP_Vj, qj_busy: DP_Qj_busy && !dj[DATA_W], qj: DP_Qj,
                             vk: dk[DATA_W] ? dk[DATA_W-1:0] : DP_Vk, qk_busy: DP_Qk_busy && !dk[DATA_W], qk: DP_Qk,
                             imm: DP_imm, rob_id: DP_ROB_id};
      end
    end
  end
endmodule

// File: doc/alu_rsv_station.md
Name: alu_rsv_station

Overview:
- Reservation station that holds decoded ALU-class instructions (LUI..SRAI, jumps, branches) until both source operands are available.
- Issues one ready instruction per cycle to ALU_RS through a registered port.
- Snoops the ALU and LSB common data buses so waiting operands are captured.
- Sits between the dispatcher (upstream) and ALU_RS (downstream); a ROB clear flushes it on mispredict.

Parameters:
RS_SIZE, 16, number of entries (power of two)
RS_IDX_W, 4, log2(RS_SIZE)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
rdy  in  1  global enable; low = freeze all state and outputs
DP_input_valid  in  1  dispatcher presents an instruction
DP_OP_ID  in  `OpIdBus  opcode id
DP_inst_pc  in  32  instruction pc
DP_Vj  in  32  rs1 value (valid when DP_Qj_busy=0)
DP_Qj_busy  in  1  rs1 awaits ROB entry DP_Qj
DP_Qj  in  `ROBIDBus  producer ROB id of rs1
DP_Vk  in  32  rs2 value
DP_Qk_busy  in  1  rs2 awaits ROB entry DP_Qk
DP_Qk  in  `ROBIDBus  producer ROB id of rs2
DP_imm  in  32  immediate, already sign-extended
DP_ROB_id  in  `ROBIDBus  destination ROB entry
RS_full  out  1  no free entry (combinational from state)
ALU_cdb_valid  in  1  ALU result broadcast
ALU_cdb_ROB_id  in  `ROBIDBus  tag of the ALU result
ALU_cdb_value  in  32  ALU result value
LSB_cdb_valid  in  1  load result broadcast
LSB_cdb_ROB_id  in  `ROBIDBus  tag of the load result
LSB_cdb_value  in  32  load result value
ROB_clear  in  1  mispredict flush
ALU_input_valid  out  1  issue strobe to ALU_RS
ALU_OP_ID  out  `OpIdBus  issued opcode
ALU_inst_pc  out  32  issued pc
ALU_reg_rs1  out  32  issued rs1 value
ALU_reg_rs2  out  32  issued rs2 value
ALU_imm  out  32  issued immediate
ALU_ROB_id  out  `ROBIDBus  issued ROB id

Behaviour:
- Reset (rst=0, async): all entry busy bits cleared; ALU_input_valid=0; all other ALU_* outputs 0; RS_full=0.
- Entry fields: busy, op, pc, Vj, Qj_busy, Qj, Vk, Qk_busy, Qk, imm, rob_id.
- rdy=0: nothing changes, including dispatch, CDB capture and clear; outputs hold their values.
- ROB_clear=1 (rdy=1): next edge clears all busy bits and sets ALU_input_valid=0. A same-cycle dispatch and CDB traffic are dropped. Clear takes priority over everything except reset.
- Wakeup, every cycle on each busy entry:
  - If Qj_busy and Qj matches a valid CDB tag, load Vj and clear Qj_busy. Same rule for Qk.
  - If both CDBs carry the same tag, the ALU value wins.
- Ready: busy and !Qj_busy and !Qk_busy, evaluated on the registered state.
- Issue:
  - Pick the lowest-index ready entry.
  - Next edge: drive ALU_* with its fields, set ALU_input_valid=1, clear its busy bit.
  - If no entry is ready, ALU_input_valid=0 next edge and the other ALU_* outputs hold.
  - Latency: an entry whose operands are ready when it is written issues at the earliest on the edge after the write. Dispatch-to-ALU_input_valid is therefore at least 2 cycles.
- Dispatch:
  - When DP_input_valid and !RS_full, write the lowest-index free entry (busy=0 in the current state) on the next edge.
  - A slot freed by issue in the same cycle is not reusable until the following cycle.
  - Dispatch-cycle forwarding: if DP_Qj_busy and DP_Qj matches a valid CDB tag this cycle, store the CDB value with Qj_busy=0. Same for k.
- Dispatch while RS_full=1 is a dispatcher protocol violation; the instruction is ignored and the state is unchanged.
- RS_full = all RS_SIZE busy bits set, from current state. It does not anticipate a same-cycle issue.
- Operands that need no register, such as LUI rs1, arrive with busy=0; the station does not interpret opcodes.

Decomposition:
- defines.v carries:
  - `RS_SIZE and `RSIdxBus;
  - the existing `OpIdBus, `ROBIDBus, `DataWidth, `ImmWidth, `True and `False.
- One sub-module, rs_priority_enc: a RS_SIZE-bit request vector in, lowest-set index plus a found flag out.
  - Instantiated twice: free-slot select and ready-entry select.

Test Plan:
- Reset mid-operation: fill 3 entries, pull rst low asynchronously -> ALU_input_valid=0 immediately, RS_full=0; after release, no issue occurs.
- Ready dispatch: ADDI with Vj=5, imm=7, rob 3, both not busy -> ALU_input_valid=1 two edges later with rs1=5, imm=7, ROB_id=3; asserted for exactly one cycle.
- Wakeup: ADD with Qj_busy, Qj=2, Vk=10 -> no issue. Then ALU_cdb tag 2, value 0x20 -> issue on the following edge with rs1=0x20, rs2=10.
- Same-cycle forwarding and tag conflict:
  - Dispatch with Qk=4 while LSB_cdb is tag 4, value 0xAB -> entry stores rs2=0xAB, not busy.
  - ALU and LSB both broadcasting tag 6 -> the ALU value is captured.
- Full and order:
  - Dispatch 16 blocked entries -> RS_full=1.
  - Wake entries 9 and 2 together -> entry 2 issues first, then entry 9.
  - RS_full drops the cycle after the first issue.
- Flush and stall:
  - ROB_clear with 5 busy entries and a concurrent dispatch -> all empty, ALU_input_valid=0, nothing issues.
  - rdy=0 for 3 cycles with a CDB match pending -> no state or output change; the wakeup does not happen.
